// File: rtl/sha256_unrolled_core.sv
// sha256_unrolled_core: SHA-256 / SHA-224 compression core retiring UNROLL
// rounds per clock (UNROLL in {1,2,4,8}), with midstate restore and abort.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   init            start a block from the IV selected by mode (1=256, 0=224)
//   next            start a block chaining from the current digest
//   block[511:0]    pre-padded message block, word 0 in [511:480]
//   midstate_load   load midstate_in (H0 in [255:224]) into the digest regs
//   abort           cancel the block in progress
//   ready           high while idle
//   digest[255:0]   {H0..H7}; SHA-224 uses digest[255:32]
//   digest_valid    high once a block has completed
//
// Build option: define SHA256_MIDSTATE_EN to enable midstate_load/midstate_in;
// when undefined both ports are ignored and midstate_load does not mask
// init/next.
module sha256_unrolled_core #(
  parameter int unsigned UNROLL = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         init,
  input  logic         next,
  input  logic         mode,
  input  logic [511:0] block,
  input  logic         midstate_load,
  input  logic [255:0] midstate_in,
  input  logic         abort,
  output logic         ready,
  output logic [255:0] digest,
  output logic         digest_valid
);

  localparam int U = int'(UNROLL);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
    $error("sha256_unrolled_core: UNROLL must be 1, 2, 4 or 8");
  end

  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [31:0] IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
  // One K table lookup per lane.
  function automatic logic [31:0] k_rom(input logic [5:0] idx);
    return K_TABLE[idx];
  endfunction

  typedef enum logic [1:0] {IDLE, ROUNDS, DONE} state_t;

  state_t      state_q, state_d;
  logic [6:0]  ctr_q, ctr_d;
  logic        dv_q, dv_d;
  logic [31:0] h_q [8], h_d [8];    // chaining value H0..H7
  logic [31:0] v_q [8], v_d [8];    // working variables a..h
  logic [31:0] w_q [16], w_d [16];  // window, w_q[0] = W[ctr]

  logic [31:0] blk_w [16];
  logic [31:0] h_sum [8];
  logic [31:0] w_shift [16];
  logic [31:0] v_rounds [8];

  for (genvar gi = 0; gi < 16; gi++) begin : g_blk
    assign blk_w[gi] = block[511-32*gi -: 32];
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_out
    assign h_sum[gi] = h_q[gi] + v_q[gi];
    assign digest[255-32*gi -: 32] = h_q[gi];
  end

  // Each lane produces one schedule word and one round. Schedule taps that
  // fall beyond the registered window come from earlier lanes' new words.
  for (genvar gj = 0; gj < U; gj++) begin : g_lane
    logic [31:0] wm2, wm7, w_new, t1, t2;
    logic [31:0] si [8];
    logic [31:0] so [8];
    logic [5:0]  kidx;

    if (gj < 2) begin : g_m2_win
      assign wm2 = w_q[14+gj];
    end else begin : g_m2_lane
      assign wm2 = g_lane[gj-2].w_new;
    end
    if (gj < 7) begin : g_m7_win
      assign wm7 = w_q[9+gj];
    end else begin : g_m7_lane
      assign wm7 = g_lane[gj-7].w_new;
    end
    if (gj == 0) begin : g_si_reg
      assign si = v_q;
    end else begin : g_si_lane
      assign si = g_lane[gj-1].so;
    end

    assign w_new = ssig1(wm2) + wm7 + ssig0(w_q[1+gj]) + w_q[gj];
    assign kidx  = ctr_q[5:0] + 6'(gj);
    assign t1    = si[7] + bsig1(si[4]) + ((si[4] & si[5]) ^ (~si[4] & si[6]))
                 + k_rom(kidx) + w_q[gj];
    assign t2    = bsig0(si[0]) + ((si[0] & si[1]) ^ (si[0] & si[2]) ^ (si[1] & si[2]));
    assign so[0] = t1 + t2;
    assign so[1] = si[0];
    assign so[2] = si[1];
    assign so[3] = si[2];
    assign so[4] = si[3] + t1;
    assign so[5] = si[4];
    assign so[6] = si[5];
    assign so[7] = si[6];
  end

  assign v_rounds = g_lane[U-1].so;

  for (genvar gi = 0; gi < 16; gi++) begin : g_win
    if (gi < 16 - U) begin : g_keep
      assign w_shift[gi] = w_q[gi+U];
    end else begin : g_new
      assign w_shift[gi] = g_lane[gi-16+U].w_new;
    end
  end

`ifdef SHA256_MIDSTATE_EN
  logic [31:0] mid_w [8];
  for (genvar gi = 0; gi < 8; gi++) begin : g_mid
    assign mid_w[gi] = midstate_in[255-32*gi -: 32];
  end
`else
  logic unused_midstate;
  assign unused_midstate = ^{midstate_load, midstate_in};
`endif

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    dv_d    = dv_q;
    h_d     = h_q;
    v_d     = v_q;
    w_d     = w_q;
    unique case (state_q)
      IDLE: begin
        if (abort) begin
          state_d = IDLE;
`ifdef SHA256_MIDSTATE_EN
        end else if (midstate_load) begin
          h_d  = mid_w;
          dv_d = 1'b0;
`endif
        end else if (init) begin
          if (mode) begin
            h_d = IV256;
            v_d = IV256;
          end else begin
            h_d = IV224;
            v_d = IV224;
          end
          w_d     = blk_w;
          ctr_d   = '0;
          dv_d    = 1'b0;
          state_d = ROUNDS;
        end else if (next) begin
          v_d     = h_q;
          w_d     = blk_w;
          ctr_d   = '0;
          dv_d    = 1'b0;
          state_d = ROUNDS;
        end
      end
      ROUNDS: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          v_d   = v_rounds;
          w_d   = w_shift;
          ctr_d = ctr_q + 7'(U);
          if (ctr_q == 7'(64 - U)) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!abort) begin
          h_d  = h_sum;
          dv_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      dv_q    <= 1'b0;
      h_q     <= '{default: '0};
      v_q     <= '{default: '0};
      w_q     <= '{default: '0};
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      dv_q    <= dv_d;
      h_q     <= h_d;
      v_q     <= v_d;
      w_q     <= w_d;
    end
  end

  assign ready        = (state_q == IDLE);
  assign digest_valid = dv_q;

endmodule

// File: tb/tb_sha256_unrolled_core.sv
// Testbench for sha256_unrolled_core: four instances (UNROLL 1,2,4,8) share
// the stimulus; the UNROLL=4 instance carries the multi-cycle sequences.
module tb_sha256_unrolled_core;

  localparam logic [511:0] BLK_ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] BLK1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK2 = {{15{32'h0}}, 32'h000001c0};
  localparam logic [255:0] ABC256 = {
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  localparam logic [255:0] ABC224 = {
    32'h23097d22, 32'h3405d822, 32'h8642a477, 32'hbda255b3,
    32'h2aadbce4, 32'hbda0b3f7, 32'he36c9da7, 32'h00000000};
  localparam logic [255:0] MASK224 = {{7{32'hffffffff}}, 32'h0};
  localparam logic [255:0] H1 = {
    32'h85e655d6, 32'h417a1795, 32'h3363376a, 32'h624cde5c,
    32'h76e09589, 32'hcac5f811, 32'hcc4b32c1, 32'hf20e533a};
  localparam logic [255:0] FINAL = {
    32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
    32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};

  typedef struct {
    logic         md;
    logic [511:0] blk;
    logic [255:0] exp;
    logic [255:0] mask;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset, init, next, mode, midstate_load, abort;
  logic [511:0] block;
  logic [255:0] midstate_in;
  logic         rdy [4];
  logic         dv  [4];
  logic [255:0] dg  [4];

  int checks = 0;
  int errors = 0;
  int cyc;
  vec_t vecs [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sha256_unrolled_core #(.UNROLL(1 << g)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .init         (init),
      .next         (next),
      .mode         (mode),
      .block        (block),
      .midstate_load(midstate_load),
      .midstate_in  (midstate_in),
      .abort        (abort),
      .ready        (rdy[g]),
      .digest       (dg[g]),
      .digest_valid (dv[g])
    );
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Waits on negedges for the UNROLL=4 instance to become ready.
  task automatic wait_ready(input string name, input int budget, output int n);
    n = 0;
    while (rdy[2] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (rdy[2] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: ready still low after %0d cycles", name, budget);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; init = 1'b0; next = 1'b0; mode = 1'b0; abort = 1'b0;
    midstate_load = 1'b0; block = '0; midstate_in = '0;

    vecs[0].md = 1'b1; vecs[0].blk = BLK_ABC; vecs[0].exp = ABC256; vecs[0].mask = '1;
    vecs[1].md = 1'b0; vecs[1].blk = BLK_ABC; vecs[1].exp = ABC224; vecs[1].mask = MASK224;
    vecs[2].md = 1'b1; vecs[2].blk = BLK1;    vecs[2].exp = H1;     vecs[2].mask = '1;

    @(negedge clk);
    @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("rst_ready_u%0d", 1 << g), 256'(rdy[g]), 256'd1);
      chk($sformatf("rst_digest_u%0d", 1 << g), dg[g], '0);
      chk($sformatf("rst_dv_u%0d", 1 << g), 256'(dv[g]), 256'd0);
    end
    reset = 1'b0;

    // Single-block vectors on every UNROLL, with latency 64/U+1 edges.
    for (int v = 0; v < 3; v++) begin
      @(negedge clk);
      init = 1'b1; mode = vecs[v].md; block = vecs[v].blk;
      @(negedge clk);
      init = 1'b0; block = '0;
      for (int g = 0; g < 4; g++)
        chk($sformatf("v%0d_busy_u%0d", v, 1 << g), 256'(rdy[g]), 256'd0);
      for (int k = 1; k <= 65; k++) begin
        @(negedge clk);
        for (int g = 0; g < 4; g++) begin
          if (k == (64 >> g)) begin
            chk($sformatf("v%0d_early_ready_u%0d", v, 1 << g), 256'(rdy[g]), 256'd0);
            chk($sformatf("v%0d_early_dv_u%0d", v, 1 << g), 256'(dv[g]), 256'd0);
          end
          if (k == (64 >> g) + 1) begin
            chk($sformatf("v%0d_ready_u%0d", v, 1 << g), 256'(rdy[g]), 256'd1);
            chk($sformatf("v%0d_dv_u%0d", v, 1 << g), 256'(dv[g]), 256'd1);
            chk($sformatf("v%0d_digest_u%0d", v, 1 << g), dg[g] & vecs[v].mask, vecs[v].exp);
          end
        end
      end
    end

    // Two-block message, next on the first ready cycle; an init pulsed
    // mid-block must be ignored.
    @(negedge clk);
    init = 1'b1; mode = 1'b1; block = BLK1;
    @(negedge clk);
    init = 1'b0;
    wait_ready("b1_wait", 40, cyc);
    chk("b1_latency", 256'(cyc), 256'd17);
    chk("b1_digest", dg[2], H1);
    next = 1'b1; block = BLK2;
    @(negedge clk);
    next = 1'b0; block = '0;
    repeat (3) @(negedge clk);
    init = 1'b1; mode = 1'b0; block = BLK_ABC;
    @(negedge clk);
    init = 1'b0; block = '0;
    wait_ready("b2_wait", 40, cyc);
    chk("b2_latency", 256'(cyc), 256'd13);
    chk("b2_digest", dg[2], FINAL);
    chk("b2_dv", 256'(dv[2]), 256'd1);

    // Abort in ROUNDS, abort in DONE, then a clean re-issue.
    @(negedge clk);
    init = 1'b1; mode = 1'b1; block = BLK1;
    @(negedge clk);
    init = 1'b0;
    wait_ready("ab_b1_wait", 40, cyc);
    next = 1'b1; block = BLK2;
    @(negedge clk);
    next = 1'b0;
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_rounds_ready", 256'(rdy[2]), 256'd1);
    chk("abort_rounds_digest", dg[2], H1);
    chk("abort_rounds_dv", 256'(dv[2]), 256'd0);
    next = 1'b1;
    @(negedge clk);
    next = 1'b0;
    repeat (16) @(negedge clk);
    chk("done_busy", 256'(rdy[2]), 256'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_done_ready", 256'(rdy[2]), 256'd1);
    chk("abort_done_digest", dg[2], H1);
    chk("abort_done_dv", 256'(dv[2]), 256'd0);
    next = 1'b1;
    @(negedge clk);
    next = 1'b0; block = '0;
    wait_ready("reissue_wait", 40, cyc);
    chk("reissue_digest", dg[2], FINAL);
    chk("reissue_dv", 256'(dv[2]), 256'd1);

    // Abort in IDLE masks a simultaneous init.
    abort = 1'b1; init = 1'b1; mode = 1'b1; block = BLK_ABC;
    @(negedge clk);
    abort = 1'b0; init = 1'b0; block = '0;
    chk("idle_abort_ready", 256'(rdy[2]), 256'd1);
    chk("idle_abort_digest", dg[2], FINAL);
    chk("idle_abort_dv", 256'(dv[2]), 256'd1);

    // Asynchronous reset in the middle of ROUNDS.
    init = 1'b1; mode = 1'b1; block = BLK_ABC;
    @(negedge clk);
    init = 1'b0; block = '0;
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", 256'(rdy[2]), 256'd0);
    reset = 1'b1;
    #1;
    chk("midrst_ready", 256'(rdy[2]), 256'd1);
    chk("midrst_digest", dg[2], '0);
    chk("midrst_dv", 256'(dv[2]), 256'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

`ifdef SHA256_MIDSTATE_EN
    // Midstate restore takes priority over init, then chains block 2.
    midstate_load = 1'b1; midstate_in = H1; init = 1'b1; mode = 1'b1; block = BLK_ABC;
    @(negedge clk);
    midstate_load = 1'b0; init = 1'b0; midstate_in = '0;
    chk("ms_ready", 256'(rdy[2]), 256'd1);
    chk("ms_digest", dg[2], H1);
    chk("ms_dv", 256'(dv[2]), 256'd0);
    next = 1'b1; mode = 1'b0; block = BLK2;
    @(negedge clk);
    next = 1'b0; block = '0;
    wait_ready("ms_wait", 40, cyc);
    chk("ms_latency", 256'(cyc), 256'd17);
    chk("ms_final", dg[2], FINAL);
    chk("ms_final_dv", 256'(dv[2]), 256'd1);
`else
    // Midstate disabled: load is a no-op and does not mask init.
    midstate_load = 1'b1; midstate_in = H1;
    @(negedge clk);
    midstate_load = 1'b0;
    chk("ms_off_digest", dg[2], '0);
    chk("ms_off_ready", 256'(rdy[2]), 256'd1);
    midstate_load = 1'b1; init = 1'b1; mode = 1'b1; block = BLK_ABC;
    @(negedge clk);
    midstate_load = 1'b0; init = 1'b0; midstate_in = '0; block = '0;
    chk("ms_off_init_taken", 256'(rdy[2]), 256'd0);
    wait_ready("ms_off_wait", 40, cyc);
    chk("ms_off_final", dg[2], ABC256);
    chk("ms_off_dv", 256'(dv[2]), 256'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
